booth_multiplier: RTL

- Sequential radix-4 Booth integer multiplier; the arithmetic inverse of the SRT divider, sharing its start/done handshake and its signedInput convention.
- Produces the full 2N-bit product p = x*y. With the optional addend it computes q*y + r, reconstructing a dividend from divider outputs.
- Sits beside the divider in the integer ALU.
- One clock; multicycle; one operation in flight.

---
 rtl/mul_pkg.sv | 30 +++
 rtl/booth_recoder.sv | 24 ++
 rtl/booth_multiplier.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and width helpers for the radix-4 Booth multiplier.
// Optional build macro understood by the multiplier: MUL_ADDEND_EN.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  // Extended operand width: even and at least n+1, so unsigned operands
  // stay non-negative once they are sign-interpreted by the Booth recoding.
  function automatic int mul_ext_width(input int n);
    return (n % 2 == 0) ? n + 2 : n + 1;
  endfunction

  // One radix-4 digit is retired per cycle.
  function automatic int mul_iters(input int n);
    return mul_ext_width(n) / 2;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps an overlapping 3-bit multiplier group
// {y[2i+1], y[2i], y[2i-1]} to a signed digit in {-2,-1,0,+1,+2}.
module booth_recoder
  import mul_pkg::*;
(
  input  logic [2:0]   grp,
  output booth_digit_t digit
);

  // Standard Booth table.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // the output unassigned, which would otherwise infer a latch.
    digit = ZERO;
    case (grp)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, start/done
// handshake. Produces the full 2N-bit product of x and y, signed or unsigned.
// Optional build macro: MUL_ADDEND_EN adds port a and computes x*y + a.
module booth_multiplier
  import mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signedInput,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
`ifdef MUL_ADDEND_EN
  input  logic [N-1:0]   a,
`endif
  output logic [2*N-1:0] p,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  localparam int M  = mul_ext_width(N);
  localparam int K  = mul_iters(N);
  localparam int CW = $clog2(K + 1);
  // High accumulator half: M+1 bits of partial product plus one guard bit.
  localparam int AW = M + 2;

  mul_state_t     state_q, state_d;
  logic [M-1:0]   x_q, x_d;
  logic [AW-1:0]  hi_q, hi_d;
  logic [M-1:0]   lo_q, lo_d;
  logic           ym1_q, ym1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgn_q, sgn_d;
  logic [2*N-1:0] p_q, p_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;

  booth_digit_t    digit;
  logic [M:0]      pp_mag;
  logic [M:0]      pp;
  logic            pp_neg;
  logic [AW-1:0]   sum;
  logic [AW+M-1:0] pair_next;
  logic [AW-1:0]   preload;

  // The low two multiplier bits plus the bit shifted out last cycle.
  booth_recoder u_recoder (
    .grp   ({lo_q[1:0], ym1_q}),
    .digit (digit)
  );

  // Result does not fit back into N bits of the selected signedness.
  function automatic logic ovf_of(input logic [2*N-1:0] prod, input logic sgn);
    logic [N:0] top;
    top = prod[2*N-1:N-1];
    if (sgn) return !((&top) || !(|top));
    else     return |prod[2*N-1:N];
  endfunction

  // Select the digit multiple of x; negatives are the inverted magnitude
  // plus a carry-in of one, so no separate negation adder is needed.
  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    case (digit)
      POS1: pp_mag = {x_q[M-1], x_q};
      POS2: pp_mag = {x_q, 1'b0};
      NEG1: begin pp_mag = {x_q[M-1], x_q}; pp_neg = 1'b1; end
      NEG2: begin pp_mag = {x_q, 1'b0};     pp_neg = 1'b1; end
      default: begin pp_mag = '0; pp_neg = 1'b0; end
    endcase
    pp        = pp_mag ^ {(M + 1){pp_neg}};
    sum       = hi_q + {pp[M], pp} + AW'(pp_neg);
    pair_next = {{2{sum[AW-1]}}, sum, lo_q[M-1:2]};
  end

  // Initial high half of the accumulator: the addend in product alignment,
  // or zero when the addend is not built in.
  always_comb begin
`ifdef MUL_ADDEND_EN
    preload = signedInput ? {{(AW - N){a[N-1]}}, a} : {{(AW - N){1'b0}}, a};
`else
    preload = '0;
`endif
  end

  // Next-state and datapath update for the IDLE/RUN/DONE handshake.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ym1_d   = ym1_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sgn_d   = signedInput;
          x_d     = signedInput ? {{(M - N){x[N-1]}}, x} : {{(M - N){1'b0}}, x};
          lo_d    = signedInput ? {{(M - N){y[N-1]}}, y} : {{(M - N){1'b0}}, y};
          ym1_d   = 1'b0;
          hi_d    = preload;
          cnt_d   = CW'(K);
          state_d = RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        hi_d  = pair_next[AW+M-1:M];
        lo_d  = pair_next[M-1:0];
        ym1_d = lo_q[1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          p_d     = pair_next[2*N-1:0];
          ovf_d   = ovf_of(pair_next[2*N-1:0], sgn_q);
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ym1_q   <= 1'b0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      x_q     <= x_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ym1_q   <= ym1_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign p    = p_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule
